// File: rtl/core_mem_arbiter_if.sv
// Memory bus port shared by the fetch unit and the data port.
// The arbiter drives it through master; the memory side connects through slave.
interface core_mem_arbiter_if;
  logic        start;
  logic [29:0] addr;
  logic        write;
  logic        user;
  logic [31:0] data_wr;
  logic [3:0]  be;
  logic        ready;
  logic        fault;
  logic [31:0] data_rd;

  modport master (
    output start, addr, write, user, data_wr, be,
    input  ready, fault, data_rd
  );

  modport slave (
    input  start, addr, write, user, data_wr, be,
    output ready, fault, data_rd
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Two-requester memory bus arbiter: fetch and data each get a one-deep request
// slot. The owner of the finished bus transaction gets a registered response.
module core_mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        insn_start,
  input  logic [29:0] insn_addr,
  output logic        insn_ready,
  output logic        insn_fault,
  output logic [31:0] insn_data,
  input  logic        data_start,
  input  logic [29:0] data_addr,
  input  logic        data_write,
  input  logic        data_user,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_be,
  output logic        data_ready,
  output logic        data_fault,
  output logic [31:0] data_rd,
  input  logic        hold,
  output logic        idle,
  core_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, INSN, DATA} state_t;

  state_t      state, state_nxt;
  logic        last_data;

  logic        insn_vld;
  logic [29:0] insn_addr_q;
  logic        data_vld;
  logic [29:0] data_addr_q;
  logic        data_write_q;
  logic        data_user_q;
  logic [31:0] data_wr_q;
  logic [3:0]  data_be_q;

  logic        bus_start_q;
  logic [29:0] bus_addr_q;
  logic        bus_write_q;
  logic        bus_user_q;
  logic [31:0] bus_data_wr_q;
  logic [3:0]  bus_be_q;

  logic        insn_acc, data_acc;
  logic        insn_cand, data_cand;
  logic        done, free;
  logic        grant_insn, grant_data;

  // A start is taken only if the slot is empty and that requester is not on the bus.
  assign insn_acc  = insn_start & ~insn_vld & (state != INSN);
  assign data_acc  = data_start & ~data_vld & (state != DATA);
  assign done      = (state != IDLE) & bus.ready;
  assign free      = (state == IDLE) | done;
  // From IDLE a fresh start competes directly; after a completion only latched slots do.
  assign insn_cand = insn_vld | ((state == IDLE) & insn_acc);
  assign data_cand = data_vld | ((state == IDLE) & data_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    grant_insn = 1'b0;
    grant_data = 1'b0;
    state_nxt  = state;
    if (done) state_nxt = IDLE;
    if (free && !hold) begin
      if (insn_cand && data_cand) begin
        if (last_data) grant_insn = 1'b1;
        else           grant_data = 1'b1;
      end else if (insn_cand) begin
        grant_insn = 1'b1;
      end else if (data_cand) begin
        grant_data = 1'b1;
      end
    end
    if (grant_insn)      state_nxt = INSN;
    else if (grant_data) state_nxt = DATA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_data     <= 1'b0;
      insn_vld      <= 1'b0;
      insn_addr_q   <= '0;
      data_vld      <= 1'b0;
      data_addr_q   <= '0;
      data_write_q  <= 1'b0;
      data_user_q   <= 1'b0;
      data_wr_q     <= '0;
      data_be_q     <= '0;
      bus_start_q   <= 1'b0;
      bus_addr_q    <= '0;
      bus_write_q   <= 1'b0;
      bus_user_q    <= 1'b0;
      bus_data_wr_q <= '0;
      bus_be_q      <= '0;
    end else begin
      bus_start_q <= grant_insn | grant_data;
      if (grant_insn) begin
        last_data     <= 1'b0;
        insn_vld      <= 1'b0;
        bus_addr_q    <= insn_vld ? insn_addr_q : insn_addr;
        bus_write_q   <= 1'b0;
        bus_user_q    <= 1'b0;
        bus_data_wr_q <= '0;
        bus_be_q      <= 4'hF;
      end else if (insn_acc) begin
        insn_vld    <= 1'b1;
        insn_addr_q <= insn_addr;
      end
      if (grant_data) begin
        last_data     <= 1'b1;
        data_vld      <= 1'b0;
        bus_addr_q    <= data_vld ? data_addr_q  : data_addr;
        bus_write_q   <= data_vld ? data_write_q : data_write;
        bus_user_q    <= data_vld ? data_user_q  : data_user;
        bus_data_wr_q <= data_vld ? data_wr_q    : data_wr;
        bus_be_q      <= data_vld ? data_be_q    : data_be;
      end else if (data_acc) begin
        data_vld     <= 1'b1;
        data_addr_q  <= data_addr;
        data_write_q <= data_write;
        data_user_q  <= data_user;
        data_wr_q    <= data_wr;
        data_be_q    <= data_be;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      insn_ready <= 1'b0;
      insn_fault <= 1'b0;
      insn_data  <= '0;
      data_ready <= 1'b0;
      data_fault <= 1'b0;
      data_rd    <= '0;
    end else begin
      insn_ready <= done & (state == INSN);
      data_ready <= done & (state == DATA);
      if (done && state == INSN) begin
        insn_fault <= bus.fault;
        insn_data  <= bus.data_rd;
      end
      if (done && state == DATA) begin
        data_fault <= bus.fault;
        data_rd    <= bus.data_rd;
      end
    end
  end

  assign bus.start   = bus_start_q;
  assign bus.addr    = bus_addr_q;
  assign bus.write   = bus_write_q;
  assign bus.user    = bus_user_q;
  assign bus.data_wr = bus_data_wr_q;
  assign bus.be      = bus_be_q;

  assign idle = (state == IDLE) & hold;

endmodule
